// File: rtl/alu_sequencer.sv
// Multi-cycle controller that feeds an external ALU from a small register file
// and writes the ALU result back with a zero flag (IDLE -> EXEC -> WB).
module alu_sequencer #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [4+3*$clog2(NREG)+DATA_W:0] instr,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [2:0]               alu_s,
  output logic                     alu_cin,
  input  logic [DATA_W-1:0]        alu_y,
  output logic                     done,
  output logic                     zero,
  output logic                     busy,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int AW = $clog2(NREG);
  localparam int IW = 5 + 3*AW + DATA_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [DATA_W-1:0] aluA_q, aluA_d;
  logic [DATA_W-1:0] aluB_q, aluB_d;
  logic [2:0]        aluS_q, aluS_d;
  logic              aluCin_q, aluCin_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              rfWe;
  logic [DATA_W-1:0] rf_q [NREG];

  logic              fCin;
  logic              fUseImm;
  logic [2:0]        fOp;
  logic [AW-1:0]     fRd;
  logic [AW-1:0]     fRa;
  logic [AW-1:0]     fRb;
  logic [DATA_W-1:0] fImm;

  assign fCin    = instr[IW-1];
  assign fUseImm = instr[IW-2];
  assign fOp     = instr[IW-3 -: 3];
  assign fRd     = instr[DATA_W+3*AW-1 -: AW];
  assign fRa     = instr[DATA_W+2*AW-1 -: AW];
  assign fRb     = instr[DATA_W+AW-1 -: AW];
  assign fImm    = instr[DATA_W-1:0];

  // Operands are read from the register file only while IDLE, after the
  // previous write-back has landed, so no forwarding path is needed.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    aluA_d   = aluA_q;
    aluB_d   = aluB_q;
    aluS_d   = aluS_q;
    aluCin_d = aluCin_q;
    result_d = result_q;
    zero_d   = zero_q;
    rfWe     = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          rd_d     = fRd;
          aluA_d   = rf_q[fRa];
          aluB_d   = fUseImm ? fImm : rf_q[fRb];
          aluS_d   = fOp;
          aluCin_d = fCin;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_y;
        state_d  = WB;
      end
      WB: begin
        rfWe    = 1'b1;
        zero_d  = (result_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      aluA_q   <= '0;
      aluB_q   <= '0;
      aluS_q   <= '0;
      aluCin_q <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      aluA_q   <= aluA_d;
      aluB_q   <= aluB_d;
      aluS_q   <= aluS_d;
      aluCin_q <= aluCin_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      if (rfWe) rf_q[rd_q] <= result_q;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = !instr_ready;
  assign done        = (state_q == WB);
  assign zero        = zero_q;
  assign alu_a       = aluA_q;
  assign alu_b       = aluB_q;
  assign alu_s       = aluS_q;
  assign alu_cin     = aluCin_q;
  assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the 4-bit ALU for the processor. It accepts one encoded instruction per handshake and reads two operands from an internal register file or an immediate. It drives the ALU's A/B/S/CIN inputs from registers, captures the ALU result, and writes it back with a zero flag. It sits between the instruction source (testbench or fetch logic) and the ALU instance, which is external to this block.

## Interface
- DATA_W, 4, operand/result width; must equal the ALU width.
- NREG, 4, register-file depth; power of two, address width AW = log2(NREG) = 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction present on instr.
- instr_ready  output  1  block can accept an instruction.
- instr  input  15  fields:
  - [14] cin
  - [13] use_imm
  - [12:10] op (ALU S code)
  - [9:8] rd
  - [7:6] ra
  - [5:4] rb
  - [3:0] imm
- alu_a  output  4  ALU operand A (registered).
- alu_b  output  4  ALU operand B (registered).
- alu_s  output  3  ALU select (registered).
- alu_cin  output  1  ALU carry-in (registered).
- alu_y  input  4  ALU combinational result.
- done  output  1  one-cycle pulse on write-back.
- zero  output  1  result of last completed instruction was 0.
- busy  output  1  high in EXEC or WB.
- dbg_addr  input  2  register-file debug read address.
- dbg_data  output  4  combinational read of rf[dbg_addr].

## Operation
- FSM states: IDLE, EXEC, WB. instr_ready = (state == IDLE). busy = !instr_ready.
- IDLE:
  - On instr_valid && instr_ready at an edge: latch rd.
  - alu_a <= rf[ra].
  - alu_b <= use_imm ? imm : rf[rb].
  - alu_s <= op. alu_cin <= cin.
  - Next state EXEC.
  - Without valid, stay in IDLE; all ALU outputs hold.
- EXEC: ALU inputs are stable for the full cycle. At the edge, result <= alu_y; next state WB.
- WB:
  - done = 1 for this cycle only.
  - At the edge, rf[rd] <= result and zero <= (result == 0).
  - Next state IDLE.
- All eight ALU ops are passed through unchanged. The block does no arithmetic itself; modulo-16 wrap is the ALU's behaviour and is written back as-is.
- The register file has no hardwired-zero register; all NREG entries are writable.
- Register-file reads for operands happen in IDLE. A back-to-back instruction always sees the previous write-back, because WB completes before the next acceptance. There are no hazards and no forwarding.
- instr_valid while busy is ignored (not latched). The source must hold instr stable until instr_ready && instr_valid.
- dbg_data reflects a write-back starting the cycle after the WB edge.

## Timing
- Reset (synchronous, at the edge with reset = 1):
  - state = IDLE.
  - All rf entries = 0.
  - alu_a, alu_b, alu_s, alu_cin, result, zero, done = 0.
  - instr_ready = 1 in the first cycle after reset.
- Reset overrides everything. Reset asserted in EXEC or WB abandons the instruction: no write-back, no done, zero cleared.
- Latency: accept edge T0. ALU driven during cycle T0 to T1. Result captured at T1. done is high during cycle T1 to T2. rf/zero are updated at T2.
- Throughput: one instruction per 3 cycles. instr_ready is high again at T2.
- An instruction presented together with reset deasserting: the edge on which reset = 1 wins and the instruction is not accepted.

## Test plan
- Reset, then program R1 = imm 3 (op 010, use_imm = 1) and R2 = imm 5. Then ADD rd=3, ra=1, rb=2, cin=0 -> dbg R3 = 8, zero = 0, done pulses exactly once per instruction, 3 cycles apart.
- SUB with carry: op 001, ra = rb = R1 (3), cin = 1 -> result 3 + ~3 + 1 = 0 (mod 16), zero = 1.
- Wrap: R0 = imm 15, ADD imm 1, cin = 0 -> 0, zero = 1. Then ADD imm 1, cin = 1 -> 2, zero = 0.
- Logic ops on A = 1010, B = 0110: AND -> 0010, OR -> 1110, XOR -> 1100, NOT A -> 0101, pass A -> 1010, pass B -> 0110.
- Backpressure: hold instr_valid high continuously with a changing instr. Only values present in IDLE cycles are accepted; instr_ready is low for exactly 2 cycles after each accept.
- Reset asserted during EXEC of an ADD targeting R3 (pre-set to 7, then reset) -> R3 = 0, done never pulses, state IDLE, instr_ready = 1 the next cycle.
